// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_state_ctrl
//  Purpose  : Top-level Flappy Bird game sequencer. Tracks the screen/game
//             state (MENU, PLAY, DEAD, OVER), issues the game reset and flap
//             pulses, gates physics/scroll with run, times the death freeze
//             and the game-over button lockout in video frames, and keeps
//             the best score seen since reset.
//  Ports    :
//    clk         in   system clock (pixel clock domain)
//    rst         in   synchronous, active-high reset
//    frame_tick  in   one-cycle pulse per video frame
//    btn         in   debounced, synchronised button level (1 = pressed)
//    collision   in   collision detector level
//    score       in   current game score [SCORE_W]
//    state       out  00 MENU, 01 PLAY, 10 DEAD, 11 OVER
//    game_rst    out  one-cycle pulse resetting bird, pipes and score
//    run         out  physics/scroll enable, high only in PLAY
//    flap        out  one-cycle flap pulse to bird physics
//    best_score  out  highest score seen since rst [SCORE_W]
//  Revision : 1.0  initial release
// ============================================================================
module game_state_ctrl #(
  parameter int DEAD_FRAMES      = 60,
  parameter int OVER_LOCK_FRAMES = 30,
  parameter int SCORE_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               btn,
  input  logic               collision,
  input  logic [SCORE_W-1:0] score,
  output logic [1:0]         state,
  output logic               game_rst,
  output logic               run,
  output logic               flap,
  output logic [SCORE_W-1:0] best_score
);

  typedef enum logic [1:0] {
    MENU = 2'b00,
    PLAY = 2'b01,
    DEAD = 2'b10,
    OVER = 2'b11
  } state_t;

  // The frame counter must reach DEAD_FRAMES-1 in DEAD and OVER_LOCK_FRAMES
  // in OVER, so it is sized for the larger of the two.
  localparam int MAX_FRAMES = (DEAD_FRAMES > OVER_LOCK_FRAMES) ? DEAD_FRAMES
                                                               : OVER_LOCK_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES < 2) ? 1 : $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0] c_dead_last = CNT_W'(DEAD_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;

  // Registered state and outputs
  state_t             r_state;
  logic               r_game_rst;
  logic               r_run;
  logic               r_flap;
  logic [SCORE_W-1:0] r_best;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_btn_q;

  // Next-state / next-output terms
  state_t             w_state_nxt;
  logic               w_game_rst_nxt;
  logic               w_flap_nxt;
  logic [SCORE_W-1:0] w_best_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_btn_rise;
  logic               w_lock_done;

  // r_btn_q resets to 1 so a button held through reset is not seen as a
  // press; only a genuine low-to-high transition counts.
  assign w_btn_rise = btn & ~r_btn_q;

  // Game-over lockout: with no lockout frames any fresh press is accepted.
  generate
    if (OVER_LOCK_FRAMES == 0) begin : g_lock_none
      assign w_lock_done = 1'b1;
    end else begin : g_lock_cnt
      localparam logic [CNT_W-1:0] c_lock = CNT_W'(OVER_LOCK_FRAMES);
      assign w_lock_done = (r_cnt >= c_lock);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_game_rst_nxt = 1'b0;
    w_flap_nxt     = 1'b0;
    w_best_nxt     = r_best;

    case (r_state)
      MENU: begin
        // The start press resets the playfield but does not flap.
        if (w_btn_rise) begin
          w_state_nxt    = PLAY;
          w_game_rst_nxt = 1'b1;
        end
      end

      PLAY: begin
        // Collision takes priority over a simultaneous press.
        if (collision) begin
          w_state_nxt = DEAD;
          if (score > r_best) begin
            w_best_nxt = score;
          end
        end else if (w_btn_rise) begin
          w_flap_nxt = 1'b1;
        end
      end

      DEAD: begin
        // Counter starts at 0 on entry, so the DEAD_FRAMES-th tick leaves.
        if (frame_tick && (r_cnt == c_dead_last)) begin
          w_state_nxt = OVER;
        end
      end

      OVER: begin
        // Presses during the lockout are dropped, not queued.
        if (w_btn_rise && w_lock_done) begin
          w_state_nxt = MENU;
        end
      end

      default: begin
        w_state_nxt = MENU;
      end
    endcase

    // Frame counter: cleared on any transition, otherwise counts frames and
    // saturates so long stays in a state cannot wrap.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (frame_tick && (r_cnt != c_cnt_max)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= MENU;
      r_game_rst <= 1'b0;
      r_run      <= 1'b0;
      r_flap     <= 1'b0;
      r_best     <= '0;
      r_cnt      <= '0;
      r_btn_q    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_game_rst <= w_game_rst_nxt;
      r_run      <= (w_state_nxt == PLAY);
      r_flap     <= w_flap_nxt;
      r_best     <= w_best_nxt;
      r_cnt      <= w_cnt_nxt;
      r_btn_q    <= btn;
    end
  end

  assign state      = r_state;
  assign game_rst   = r_game_rst;
  assign run        = r_run;
  assign flap       = r_flap;
  assign best_score = r_best;

endmodule
`default_nettype wire

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level game sequencer for Flappy Bird.
- Produces the 2-bit screen/game `state` consumed by the menu/overlay RGB multiplexer and the game-logic enables.
- Handles start, flap, collision, the death freeze, the game-over lockout and best-score tracking.
- Sits between the debounced button / collision detector / score counter and the draw and physics blocks.
- Frame-rate timing is derived from a one-cycle-per-frame tick.

Parameters:
- DEAD_FRAMES, 60, frames spent in DEAD (freeze/fall) before OVER screen; legal range 1..255.
- OVER_LOCK_FRAMES, 30, frames after entering OVER during which the button is ignored; legal range 0..255.
- SCORE_W, 8, width of the score and best_score buses.

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame (e.g. at vsync start).
- btn  in  1  debounced, synchronised button level; 1 = pressed.
- collision  in  1  level from collision detector; valid in any cycle.
- score  in  SCORE_W  current game score from score counter.
- state  out  2  00 MENU, 01 PLAY, 10 DEAD, 11 OVER.
- game_rst  out  1  one-cycle pulse that resets bird, pipes and score.
- run  out  1  physics/scroll enable; 1 only in PLAY.
- flap  out  1  one-cycle flap pulse to bird physics.
- best_score  out  SCORE_W  highest score seen since rst.

Behaviour:
- Reset: clk and rst as already decided (clock clk; reset rst, synchronous, active-high).
- Reset values: state=MENU, game_rst=0, run=0, flap=0, best_score=0, frame counter=0, btn_q=1.
- All outputs are registered. Input-to-output latency is 1 clk.
- Edge detect: btn_rise = btn & ~btn_q, with btn_q <= btn every cycle.
  - Because btn_q resets to 1, a button held through reset does not generate a rise.
- run equals (state==PLAY), updated in the same edge as state.
- Frame counter:
  - Width is enough for max(DEAD_FRAMES, OVER_LOCK_FRAMES).
  - Cleared on every state transition.
  - Increments on frame_tick and saturates at its maximum.
- MENU:
  - btn_rise -> PLAY, with game_rst=1 for exactly that edge (same cycle state becomes 01).
  - No flap is generated for the start press.
  - collision is ignored.
- PLAY:
  - btn_rise with collision=0 -> flap=1 for one cycle; state stays PLAY.
  - collision=1 -> DEAD.
  - On that same edge, best_score <= score if score > best_score (unsigned compare).
  - Collision and btn_rise in the same cycle: DEAD wins and no flap pulse is issued.
- DEAD:
  - run=0. Button and collision are ignored.
  - On a frame_tick when the counter equals DEAD_FRAMES-1 -> OVER.
  - DEAD therefore lasts exactly DEAD_FRAMES ticks.
- OVER:
  - Presses are not queued: a btn_rise while counter < OVER_LOCK_FRAMES is discarded.
  - btn_rise with counter >= OVER_LOCK_FRAMES -> MENU.
  - With OVER_LOCK_FRAMES=0 the first btn_rise is accepted immediately.
  - A button held from DEAD into OVER does not count; a fresh rise is required.
- game_rst and flap are never high simultaneously, and never high outside the cases above.
- rst asserted in any state returns all outputs to reset values on the next edge.
  - An in-flight flap or game_rst pulse is cancelled.
  - best_score is cleared.
- best_score only changes on PLAY->DEAD. Equal scores do not update it.

Test Plan:
Bench uses DEAD_FRAMES=4, OVER_LOCK_FRAMES=2, SCORE_W=8; frame_tick every 10 clk.
1. Reset with btn held at 1, then release and press -> no transition while held. On the new rise: state 00->01, game_rst high exactly 1 clk, flap=0, run=1.
2. In PLAY, three rises 5 clk apart -> three single-clk flap pulses, each 1 clk after its rise; state stays 01.
3. In PLAY with score=7, best=0, assert collision and btn_rise in the same clk -> state=10, run=0, no flap, best_score=7.
4. In DEAD, count frame_ticks -> state becomes 11 on the edge of the 4th tick. Button presses during DEAD cause no change.
5. In OVER:
   - A press before the 2nd tick is ignored.
   - A press after 2 ticks -> state=00.
   - Replay with score=5 -> best_score stays 7.
   - Replay with score=9 -> best_score becomes 9.
6. Assert rst mid-PLAY on the same clk as a btn_rise -> next edge: state=00, flap=0, game_rst=0, best_score=0.
